// File: rtl/i2s_tx_out.sv
// Philips I2S transmitter: serialises each mono sample from the FIR stage
// onto both slots of a frame, with BCLK/LRCLK derived from i_clk.
module i2s_tx_out #(
  parameter int SAMP_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_DIV   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_samp_valid,
  input  logic [SAMP_WIDTH-1:0] i_samp_data,
  output logic                  o_samp_ready,
  output logic                  o_bclk,
  output logic                  o_lrclk,
  output logic                  o_sdata,
  output logic                  o_frame_start,
  output logic                  o_underrun
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  logic        [DIV_W-1:0]      div_cnt;
  logic        [BIT_W-1:0]      bit_cnt;
  logic        [BIT_W-1:0]      bit_nxt;
  logic        [BIT_W-1:0]      slot_pos;
  logic                         div_tc;
  logic                         fall;
  logic                         wrap;
  logic                         accept;
  logic signed [SAMP_WIDTH-1:0] hold_data;
  logic signed [SAMP_WIDTH-1:0] frame_sample;
  logic signed [SAMP_WIDTH-1:0] new_sample;
  logic signed [SAMP_WIDTH-1:0] shreg;

  always_comb begin
    div_tc   = (div_cnt == DIV_W'(BCLK_DIV - 1));
    fall     = div_tc & o_bclk;
    wrap     = (bit_cnt == BIT_W'(FRAME_BITS - 1));
    bit_nxt  = wrap ? '0 : bit_cnt + BIT_W'(1);
    slot_pos = (bit_nxt >= BIT_W'(SLOT_WIDTH)) ? bit_nxt - BIT_W'(SLOT_WIDTH) : bit_nxt;
    accept   = i_samp_valid & o_samp_ready;
    // An empty holding register at frame start means this frame carries silence.
    new_sample = o_samp_ready ? '0 : hold_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_cnt       <= '0;
      o_bclk        <= 1'b0;
      bit_cnt       <= BIT_W'(FRAME_BITS - 1);
      o_lrclk       <= 1'b0;
      o_sdata       <= 1'b0;
      o_frame_start <= 1'b0;
      o_underrun    <= 1'b0;
      o_samp_ready  <= 1'b1;
      shreg         <= '0;
    end else begin
      o_frame_start <= 1'b0;
      o_underrun    <= 1'b0;
      if (div_tc) begin
        div_cnt <= '0;
        o_bclk  <= ~o_bclk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (fall) begin
        bit_cnt <= bit_nxt;
        o_lrclk <= (bit_nxt >= BIT_W'(SLOT_WIDTH));
        // Slot position 0 is the I2S one-bit delay; reload the shifter there.
        if (slot_pos == '0) begin
          o_sdata <= 1'b0;
          shreg   <= wrap ? new_sample : frame_sample;
        end else if (slot_pos <= BIT_W'(SAMP_WIDTH)) begin
          o_sdata <= shreg[SAMP_WIDTH-1];
          shreg   <= shreg <<< 1;
        end else begin
          o_sdata <= 1'b0;
        end
        if (wrap) begin
          o_frame_start <= 1'b1;
          o_underrun    <= o_samp_ready;
          o_samp_ready  <= 1'b1;
        end
      end
      // Accept only happens while empty, so it never collides with the drain above.
      if (accept) begin
        o_samp_ready <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      hold_data <= i_samp_data;
    end
    if (fall && wrap) begin
      frame_sample <= new_sample;
    end
  end

endmodule

// File: tb/tb_i2s_tx_out.sv
// Directed bench for i2s_tx_out: one 32-bit-slot instance (BCLK_DIV=2) and
// one 25-bit-slot instance (BCLK_DIV=1), frames checked bit by bit.
module tb_i2s_tx_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_rst_n, a_valid, a_ready, a_bclk, a_lrclk, a_sdata, a_fs, a_ur;
  logic [23:0] a_data;
  logic        b_rst_n, b_valid, b_ready, b_bclk, b_lrclk, b_sdata, b_fs, b_ur;
  logic [23:0] b_data;

  int total = 0;
  int bad   = 0;

  i2s_tx_out #(.SAMP_WIDTH(24), .SLOT_WIDTH(32), .BCLK_DIV(2)) dut_a (
    .i_clk(clk), .i_rst_n(a_rst_n), .i_samp_valid(a_valid), .i_samp_data(a_data),
    .o_samp_ready(a_ready), .o_bclk(a_bclk), .o_lrclk(a_lrclk), .o_sdata(a_sdata),
    .o_frame_start(a_fs), .o_underrun(a_ur)
  );

  i2s_tx_out #(.SAMP_WIDTH(24), .SLOT_WIDTH(25), .BCLK_DIV(1)) dut_b (
    .i_clk(clk), .i_rst_n(b_rst_n), .i_samp_valid(b_valid), .i_samp_data(b_data),
    .o_samp_ready(b_ready), .o_bclk(b_bclk), .o_lrclk(b_lrclk), .o_sdata(b_sdata),
    .o_frame_start(b_fs), .o_underrun(b_ur)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_bits(input logic [23:0] s, input int sw);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 2 * sw; k++) begin
      if ((k % sw) >= 1 && (k % sw) <= 24) r[k] = s[24 - (k % sw)];
    end
    return r;
  endfunction

  function automatic logic [63:0] exp_lr(input int sw);
    logic [63:0] r;
    r = '0;
    for (int k = sw; k < 2 * sw; k++) r[k] = 1'b1;
    return r;
  endfunction

  // Collects sdata/lrclk on each BCLK rising edge, starting just after a frame start.
  task automatic capture(input bit sel, input int nbits, output logic [63:0] bits,
                         output logic [63:0] lr);
    logic prev, cur;
    int n, guard;
    bits = '0; lr = '0; n = 0; guard = 0;
    prev = sel ? b_bclk : a_bclk;
    while (n < nbits && guard < 2000) begin
      @(negedge clk);
      guard++;
      cur = sel ? b_bclk : a_bclk;
      if (cur && !prev) begin
        bits[n] = sel ? b_sdata : a_sdata;
        lr[n]   = sel ? b_lrclk : a_lrclk;
        n++;
      end
      prev = cur;
    end
    chk("capture_done", 64'(n), 64'(nbits));
  endtask

  task automatic wait_fs(input bit sel, output logic ur);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!(sel ? b_fs : a_fs) && g < 1000);
    chk("frame_start_seen", 64'(sel ? b_fs : a_fs), 64'(1));
    ur = sel ? b_ur : a_ur;
  endtask

  task automatic check_frame_a(input string tag, input logic [23:0] s);
    logic [63:0] bits, lr;
    capture(1'b0, 64, bits, lr);
    chk({tag, "_sdata"}, bits, exp_bits(s, 32));
    chk({tag, "_lrclk"}, lr, exp_lr(32));
  endtask

  // Releases reset at a negedge and checks the first four cycles of BCLK timing.
  task automatic release_a(input string tag);
    @(negedge clk);
    a_rst_n = 1'b1;
    @(negedge clk);
    chk({tag, "_c1_bclk"}, 64'(a_bclk), 64'(0));
    @(negedge clk);
    chk({tag, "_c2_bclk"}, 64'(a_bclk), 64'(1));
    @(negedge clk);
    chk({tag, "_c3_bclk"}, 64'(a_bclk), 64'(1));
    chk({tag, "_c3_fs"}, 64'(a_fs), 64'(0));
    @(negedge clk);
    chk({tag, "_c4_bclk"}, 64'(a_bclk), 64'(0));
    chk({tag, "_c4_fs"}, 64'(a_fs), 64'(1));
    chk({tag, "_c4_underrun"}, 64'(a_ur), 64'(1));
    chk({tag, "_c4_ready"}, 64'(a_ready), 64'(1));
  endtask

  initial begin
    logic        ur;
    logic [63:0] bits, lr;
    int          g, fs_cyc;
    a_rst_n = 1'b0; a_valid = 1'b0; a_data = '0;
    b_rst_n = 1'b0; b_valid = 1'b0; b_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_bclk", 64'(a_bclk), 64'(0));
    chk("rst_lrclk", 64'(a_lrclk), 64'(0));
    chk("rst_sdata", 64'(a_sdata), 64'(0));
    chk("rst_fs", 64'(a_fs), 64'(0));
    chk("rst_underrun", 64'(a_ur), 64'(0));
    chk("rst_ready", 64'(a_ready), 64'(1));

    release_a("rel");
    check_frame_a("idle_frame", 24'h000000);

    a_valid = 1'b1; a_data = 24'hA5F00F;
    chk("a5_ready_before", 64'(a_ready), 64'(1));
    @(negedge clk);
    a_valid = 1'b0;
    chk("a5_ready_after", 64'(a_ready), 64'(0));
    wait_fs(1'b0, ur);
    chk("a5_underrun", 64'(ur), 64'(0));
    chk("a5_ready_drained", 64'(a_ready), 64'(1));
    check_frame_a("a5_frame", 24'hA5F00F);

    a_valid = 1'b1; a_data = 24'h000001;
    @(negedge clk);
    a_data = 24'h7FFFFF;
    chk("bp_stall_ready", 64'(a_ready), 64'(0));
    wait_fs(1'b0, ur);
    chk("bp1_underrun", 64'(ur), 64'(0));
    @(negedge clk);
    a_valid = 1'b0;
    chk("bp2_accepted", 64'(a_ready), 64'(0));
    check_frame_a("bp1_frame", 24'h000001);
    wait_fs(1'b0, ur);
    chk("bp2_underrun", 64'(ur), 64'(0));
    check_frame_a("bp2_frame", 24'h7FFFFF);

    @(negedge clk);
    a_valid = 1'b1; a_data = 24'h800000;
    chk("fsacc_ready", 64'(a_ready), 64'(1));
    @(negedge clk);
    a_valid = 1'b0;
    chk("fsacc_fs", 64'(a_fs), 64'(1));
    chk("fsacc_underrun", 64'(a_ur), 64'(1));
    chk("fsacc_held", 64'(a_ready), 64'(0));
    check_frame_a("fsacc_zero_frame", 24'h000000);
    wait_fs(1'b0, ur);
    chk("fsacc_next_underrun", 64'(ur), 64'(0));
    check_frame_a("fsacc_frame", 24'h800000);

    a_valid = 1'b1; a_data = 24'h123456;
    @(negedge clk);
    a_valid = 1'b0;
    wait_fs(1'b0, ur);
    chk("mid_underrun", 64'(ur), 64'(0));
    a_valid = 1'b1; a_data = 24'h654321;
    @(negedge clk);
    a_valid = 1'b0;
    chk("mid_full", 64'(a_ready), 64'(0));
    g = 0;
    while (!a_lrclk && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("mid_right_slot", 64'(a_lrclk), 64'(1));
    repeat (5) @(negedge clk);
    #2 a_rst_n = 1'b0;
    #1;
    chk("async_bclk", 64'(a_bclk), 64'(0));
    chk("async_lrclk", 64'(a_lrclk), 64'(0));
    chk("async_sdata", 64'(a_sdata), 64'(0));
    chk("async_ready", 64'(a_ready), 64'(1));
    release_a("rerel");
    check_frame_a("discard_frame", 24'h000000);

    @(negedge clk);
    b_rst_n = 1'b1; b_valid = 1'b1; b_data = 24'hC00001;
    chk("b_ready", 64'(b_ready), 64'(1));
    @(negedge clk);
    b_valid = 1'b0;
    wait_fs(1'b1, ur);
    chk("b_first_underrun", 64'(ur), 64'(0));
    fs_cyc = cyc;
    capture(1'b1, 50, bits, lr);
    chk("b_sdata", bits, exp_bits(24'hC00001, 25));
    chk("b_lrclk", lr, exp_lr(25));
    wait_fs(1'b1, ur);
    chk("b_frame_cycles", 64'(cyc - fs_cyc), 64'(100));
    chk("b_second_underrun", 64'(ur), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_tx_out.md
Name: i2s_tx_out

Overview:
- Downstream stage of the lowpass FIR top level. Consumes the 24-bit gained filter output through a valid/ready handshake.
- Serialises each sample as a standard Philips I2S frame to the DAC codec.
- Generates BCLK and LRCLK from i_clk. The mono sample is transmitted on both the left and right slots.
- One-entry holding register decouples the filter sample rate from the frame rate; underrun is flagged.

Parameters:
- SAMP_WIDTH, 24: sample width in bits, MSB first, two's complement passed through unchanged.
- SLOT_WIDTH, 32: BCLK periods per channel slot; must be >= SAMP_WIDTH+1.
- BCLK_DIV, 4: i_clk cycles per BCLK half-period; must be >= 1.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_samp_valid  in  1  i_samp_data is valid this cycle
- i_samp_data  in  SAMP_WIDTH  sample from the FIR stage
- o_samp_ready  out  1  holding register empty; a transfer occurs when valid & ready
- o_bclk  out  1  I2S bit clock
- o_lrclk  out  1  word select; 0 = left, 1 = right
- o_sdata  out  1  serial data; changes on BCLK falling edge
- o_frame_start  out  1  one-cycle pulse on the i_clk cycle a frame begins
- o_underrun  out  1  one-cycle pulse when a frame starts with the holding register empty

Behaviour:
- Reset is asynchronous and active-low, one clock domain (i_clk).
- Reset values:
  - o_bclk=0, o_lrclk=0, o_sdata=0, o_frame_start=0, o_underrun=0.
  - Holding register empty, so o_samp_ready=1.
  - div_cnt=0, bit_cnt=2*SLOT_WIDTH-1, shift register=0.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1. At terminal count it wraps and o_bclk toggles.
  - BCLK period = 2*BCLK_DIV i_clk cycles.
- Falling-edge event: the cycle in which o_bclk toggles 1->0, i.e. all registered outputs update together.
  - bit_cnt increments mod 2*SLOT_WIDTH.
  - o_lrclk = (new bit_cnt >= SLOT_WIDTH).
  - o_sdata is driven per slot position p = bit_cnt mod SLOT_WIDTH:
    - p=0: 0 (I2S one-bit delay).
    - 1 <= p <= SAMP_WIDTH: frame_sample[SAMP_WIDTH-p], so the MSB is at p=1.
    - p > SAMP_WIDTH: 0.
  - The right slot repeats the same frame_sample.
- Frame start: the falling-edge event where bit_cnt wraps to 0.
  - If the holding register is full: copy it to frame_sample and mark it empty (o_samp_ready=1 next cycle).
  - If it is empty: frame_sample=0 and o_underrun pulses.
  - o_frame_start pulses in this same cycle.
- Handshake:
  - o_samp_ready = holding register empty; registered, no combinational path from i_samp_valid.
  - On valid & ready the holding register captures i_samp_data and becomes full; ready drops the next cycle.
  - No bypass: a sample accepted in the frame-start cycle with the register empty goes into the holding register. That frame sends zeros, underrun pulses, and the sample goes out in the next frame.
- Reset mid-frame: all outputs return to reset values immediately and the held sample is discarded. After release the first falling-edge event occurs at i_clk cycle 2*BCLK_DIV and is a frame start.
- Latency: a sample held before a frame start has its MSB on o_sdata 1 BCLK period after that frame start.

Test Plan:
- Reset release with BCLK_DIV=2, no input:
  - o_bclk toggles every 2 i_clk cycles.
  - First frame start at cycle 4 with o_underrun=1.
  - o_sdata stays 0 for the whole 64-BCLK frame.
- Send 0xA5F00F once, before the first frame start:
  - Left slot p=1..24 = 1010_0101_1111_0000_0000_1111 sampled on BCLK rising edges.
  - p=0 and p=25..31 are 0.
  - The right slot (o_lrclk=1) is identical.
- Backpressure: valid held high with 0x000001 then 0x7FFFFF:
  - Second sample stalls with ready=0 until the next frame start.
  - Frame 1 carries 0x000001, frame 2 carries 0x7FFFFF, no underrun.
- Accept 0x800000 exactly in a frame-start cycle with the register empty:
  - That frame is all zeros with o_underrun=1.
  - The next frame transmits 0x800000, i.e. MSB 1, then 23 zeros.
- Assert i_rst_n low mid-right-slot while the register is full:
  - Outputs reset asynchronously and ready=1.
  - After release the frame restarts per the reset-release timing with underrun flagged (held sample discarded).
- Run SLOT_WIDTH=25, BCLK_DIV=1:
  - Frame is 50 BCLK periods.
  - LSB at p=24, and p=0 of the right slot is 0.
